receptor_uart_triple: RTL and testbench
=======================================

Name: receptor_uart_triple

Overview:
- Upstream receive front-end of the packet processor on each ring node.
- Deserialises three independent 8N1 UART lines (ports A, B, C) into bytes.
- Arbitrates completed bytes onto a single shared byte bus with one-cycle per-port completion strobes. At most one strobe is asserted in any cycle.
- Its outputs connect directly to the processor's recepcionFinalizadaA/B/C and datoRecibido inputs.

Parameters:
- CICLOS_POR_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range is 4 or more.

Ports:
- reloj  input  1  system clock; all logic on posedge.
- reinicio  input  1  asynchronous, active-low reset.
- rxA  input  1  serial line A; idle high; asynchronous to reloj.
- rxB  input  1  serial line B; same rules as rxA.
- rxC  input  1  serial line C; same rules as rxA.
- recepcionFinalizadaA  output  1  one-cycle pulse: datoRecibido holds a byte received on A.
- recepcionFinalizadaB  output  1  one-cycle pulse: datoRecibido holds a byte received on B.
- recepcionFinalizadaC  output  1  one-cycle pulse: datoRecibido holds a byte received on C.
- datoRecibido  output  8  last delivered byte. [7:4] is the destination ID, [3:0] is the payload.
- contadorErrores  output  4  saturating count of framing errors, all ports combined.

Behaviour:
- Reset (reinicio=0, asynchronous):
  - All strobes 0, datoRecibido 0x00, contadorErrores 0.
  - All pending flags cleared.
  - Synchroniser flops set to 1.
  - Channel FSMs go to ESPERA_REPOSO.
  - Round-robin pointer set to "last served = C".
- Per-channel path: 2-flop synchroniser, then an FSM with a bit-timer of width $clog2(CICLOS_POR_BIT)+1.
- FSM states:
  - ESPERA_REPOSO: go to REPOSO when the synchronised line reads 1. This means a line held low through reset release never starts a frame.
  - REPOSO: a synchronised 0 starts the timer and moves to INICIO.
  - INICIO: after CICLOS_POR_BIT/2 cycles, sample the line.
    - If 1: false start; return to REPOSO. No error is counted.
    - If 0: go to DATOS.
  - DATOS: sample every CICLOS_POR_BIT cycles, 8 samples, LSB first, into a shift register. Then go to PARADA.
  - PARADA: sample after CICLOS_POR_BIT cycles.
    - If 1: load the byte into the channel holding register, set the pending flag, go to REPOSO.
    - If 0: framing error. Discard the byte, increment contadorErrores (saturates at 15, no wrap), go to ESPERA_REPOSO.
- Arbiter (registered output stage):
  - Each cycle, grant at most one channel whose pending flag is set, in round-robin order starting after the last served channel.
  - On the grant edge: the granted strobe is 1 for exactly one cycle, datoRecibido takes the holding register, pending clears, and the pointer updates.
  - datoRecibido holds its value between strobes.
  - If no flag is pending, all strobes are 0.
- Latency: stop-bit sample edge E sets pending. The earliest strobe is at edge E+1; the worst case is E+3 when all three channels are pending.
- Simultaneous grant and new completion on the same channel at the same edge: the new byte loads and pending stays 1. No byte is lost and no error is counted.
- Overrun cannot occur, because a frame is at least 10*CICLOS_POR_BIT cycles, which is greater than 3. No overrun logic is needed.
- Reset mid-frame: the partial byte is discarded and no strobe is emitted. Normal reception resumes after release once the line is seen high.

Test Plan:
All scenarios use CICLOS_POR_BIT=16.
- Single byte: send 0x3A on rxA -> exactly one recepcionFinalizadaA pulse, datoRecibido=0x3A, B/C strobes stay 0, contadorErrores=0.
- Simultaneous frames: 0x11 on A, 0x22 on B, 0x33 on C, all starting the same cycle -> strobes A, B, C on three consecutive cycles with data 0x11, 0x22, 0x33. Never two strobes high together.
- Framing error: 0x55 on rxB with stop bit 0, then line high, then a valid 0x66 -> no strobe for 0x55, contadorErrores=1, then recepcionFinalizadaB with 0x66.
- Glitch: rxC low for 4 cycles, less than the half-bit of 8 -> no strobe, contadorErrores unchanged, FSM back in REPOSO.
- Reset mid-frame: assert reinicio during bit 3 of a byte on rxA -> outputs 0 immediately, without waiting for a clock edge. After release with the line high, send 0x81 -> strobe A, datoRecibido=0x81.
- Saturation: 17 consecutive framing errors on rxA -> contadorErrores=15, with no wrap.

Source files
------------

// File: rtl/receptor_uart_triple.sv
// Three-line 8N1 UART receive front-end: per-line deserialiser plus a
// round-robin output stage that delivers one byte per cycle onto a shared bus.

module receptor_uart_canal #(
  parameter int CICLOS_POR_BIT = 434,
  parameter int TW             = $clog2(CICLOS_POR_BIT) + 1
) (
  input  logic       reloj,
  input  logic       reinicio,
  input  logic       rx,
  output logic       fin_o,
  output logic       err_o,
  output logic [7:0] dato_o
);
  typedef enum logic [2:0] {ESPERA_REPOSO, REPOSO, INICIO, DATOS, PARADA} estado_t;

  localparam logic [TW-1:0] FIN_BIT = TW'(CICLOS_POR_BIT - 1);
  localparam logic [TW-1:0] MITAD   = TW'(CICLOS_POR_BIT / 2 - 1);

  estado_t       est_q, est_d;
  logic [1:0]    sinc_q, sinc_d;
  logic [TW-1:0] tim_q, tim_d;
  logic [2:0]    nbit_q, nbit_d;
  logic [7:0]    desp_q, desp_d;
  logic          rx_s;

  assign rx_s   = sinc_q[1];
  assign dato_o = desp_q;

  always_comb begin
    sinc_d = {sinc_q[0], rx};
    est_d  = est_q;
    tim_d  = tim_q;
    nbit_d = nbit_q;
    desp_d = desp_q;
    fin_o  = 1'b0;
    err_o  = 1'b0;
    case (est_q)
      ESPERA_REPOSO: if (rx_s) est_d = REPOSO;
      REPOSO: if (!rx_s) begin
        tim_d = '0;
        est_d = INICIO;
      end
      INICIO: if (tim_q == MITAD) begin
        tim_d  = '0;
        nbit_d = '0;
        est_d  = rx_s ? REPOSO : DATOS;
      end else tim_d = tim_q + TW'(1);
      DATOS: if (tim_q == FIN_BIT) begin
        tim_d  = '0;
        desp_d = {rx_s, desp_q[7:1]};
        nbit_d = nbit_q + 3'd1;
        if (nbit_q == 3'd7) est_d = PARADA;
      end else tim_d = tim_q + TW'(1);
      PARADA: if (tim_q == FIN_BIT) begin
        tim_d = '0;
        fin_o = rx_s;
        err_o = !rx_s;
        // A low stop bit may mean a break; wait for idle before re-arming.
        est_d = rx_s ? REPOSO : ESPERA_REPOSO;
      end else tim_d = tim_q + TW'(1);
      default: est_d = ESPERA_REPOSO;
    endcase
  end

  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      est_q  <= ESPERA_REPOSO;
      sinc_q <= 2'b11;
      tim_q  <= '0;
      nbit_q <= '0;
      desp_q <= '0;
    end else begin
      est_q  <= est_d;
      sinc_q <= sinc_d;
      tim_q  <= tim_d;
      nbit_q <= nbit_d;
      desp_q <= desp_d;
    end
  end
endmodule

module receptor_uart_triple #(
  parameter int CICLOS_POR_BIT = 434
) (
  input  logic       reloj,
  input  logic       reinicio,
  input  logic       rxA,
  input  logic       rxB,
  input  logic       rxC,
  output logic       recepcionFinalizadaA,
  output logic       recepcionFinalizadaB,
  output logic       recepcionFinalizadaC,
  output logic [7:0] datoRecibido,
  output logic [3:0] contadorErrores
);
  localparam int TW = $clog2(CICLOS_POR_BIT) + 1;

  logic [2:0]      rx_v, fin, err;
  logic [2:0][7:0] dato_c;
  logic [2:0][7:0] hold_q, hold_d;
  logic [2:0]      pend_q, pend_d, strb_q, strb_d;
  logic [1:0]      ptr_q, ptr_d, c1, c2, c3, sel;
  logic [7:0]      dato_q, dato_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [4:0]      suma;
  logic            hay;

  assign rx_v = {rxC, rxB, rxA};

  for (genvar g = 0; g < 3; g++) begin : g_canal
    receptor_uart_canal #(.CICLOS_POR_BIT(CICLOS_POR_BIT), .TW(TW)) u_canal (
      .reloj(reloj), .reinicio(reinicio), .rx(rx_v[g]),
      .fin_o(fin[g]), .err_o(err[g]), .dato_o(dato_c[g])
    );
  end

  function automatic logic [1:0] siguiente(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    c1  = siguiente(ptr_q);
    c2  = siguiente(c1);
    c3  = siguiente(c2);
    hay = 1'b1;
    sel = c1;
    if (pend_q[c1])      sel = c1;
    else if (pend_q[c2]) sel = c2;
    else if (pend_q[c3]) sel = c3;
    else                 hay = 1'b0;
    strb_d = hay ? (3'b001 << sel) : 3'b000;
    dato_d = hay ? hold_q[sel] : dato_q;
    ptr_d  = hay ? sel : ptr_q;
    // A completion landing on the grant edge re-arms pending with the new byte.
    pend_d = (pend_q & ~strb_d) | fin;
    for (int i = 0; i < 3; i++) hold_d[i] = fin[i] ? dato_c[i] : hold_q[i];
    suma  = {1'b0, cnt_q} + 5'(err[0]) + 5'(err[1]) + 5'(err[2]);
    cnt_d = (suma > 5'd15) ? 4'd15 : suma[3:0];
  end

  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      hold_q <= '0;
      pend_q <= '0;
      strb_q <= '0;
      ptr_q  <= 2'd2;
      dato_q <= '0;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      pend_q <= pend_d;
      strb_q <= strb_d;
      ptr_q  <= ptr_d;
      dato_q <= dato_d;
      cnt_q  <= cnt_d;
    end
  end

  assign recepcionFinalizadaA = strb_q[0];
  assign recepcionFinalizadaB = strb_q[1];
  assign recepcionFinalizadaC = strb_q[2];
  assign datoRecibido         = dato_q;
  assign contadorErrores      = cnt_q;
endmodule

// File: tb/tb_receptor_uart_triple.sv
// Bench for receptor_uart_triple: directed table, corner sequences and
// randomized frames checked against a per-port byte/error model.

module tb_receptor_uart_triple;
  localparam int CPB = 16;

  logic       reloj = 1'b0;
  logic       reinicio = 1'b0;
  logic       rx [3];
  logic       finA, finB, finC;
  logic [7:0] dato;
  logic [3:0] cnt;

  int checks = 0, fails = 0, cyc = 0, model_err = 0;

  typedef struct { int port; logic [7:0] data; int cy; } ev_t;
  ev_t evq[$];

  typedef struct { int port; logic [7:0] data; logic stop; int exp_err; } vec_t;
  vec_t tabla[6];

  receptor_uart_triple #(.CICLOS_POR_BIT(CPB)) dut (
    .reloj(reloj), .reinicio(reinicio),
    .rxA(rx[0]), .rxB(rx[1]), .rxC(rx[2]),
    .recepcionFinalizadaA(finA), .recepcionFinalizadaB(finB),
    .recepcionFinalizadaC(finC),
    .datoRecibido(dato), .contadorErrores(cnt)
  );

  always #5 reloj = ~reloj;
  always @(posedge reloj) cyc++;

  // Strobe monitor: records every delivered byte and checks exclusivity.
  always @(negedge reloj) begin
    logic [2:0] s;
    s = {finC, finB, finA};
    if (s != 3'b000) begin
      checks++;
      if ($countones(s) > 1) begin
        fails++;
        $display("FAIL onehot: strobes=%b, required at most one high", s);
      end
      for (int p = 0; p < 3; p++)
        if (s[p]) evq.push_back('{port: p, data: dato, cy: cyc});
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge reloj);
  endtask

  task automatic send(input int p, input logic [7:0] b, input logic stop);
    rx[p] = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx[p] = b[i];
      wait_cyc(CPB);
    end
    rx[p] = stop;
    wait_cyc(CPB);
    rx[p] = 1'b1;
  endtask

  task automatic expect_one(input string nm, input int p, input logic [7:0] d);
    chk({nm, "_count"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      chk({nm, "_port"}, evq[0].port, p);
      chk({nm, "_data"}, int'(evq[0].data), int'(d));
    end
    evq.delete();
  endtask

  initial begin
    rx[0] = 1'b1; rx[1] = 1'b1; rx[2] = 1'b1;
    tabla[0] = '{0, 8'h3A, 1'b1, 0};
    tabla[1] = '{1, 8'h55, 1'b0, 1};
    tabla[2] = '{1, 8'h66, 1'b1, 1};
    tabla[3] = '{2, 8'h00, 1'b1, 1};
    tabla[4] = '{0, 8'hFF, 1'b1, 1};
    tabla[5] = '{1, 8'h0F, 1'b0, 2};

    // Reset state
    wait_cyc(4);
    chk("rst_strobes", int'({finC, finB, finA}), 0);
    chk("rst_dato", int'(dato), 0);
    chk("rst_cnt", int'(cnt), 0);
    reinicio = 1'b1;
    wait_cyc(8);

    // Simultaneous frames: pointer starts at C, so service order is A, B, C
    evq.delete();
    fork
      send(0, 8'h11, 1'b1);
      send(1, 8'h22, 1'b1);
      send(2, 8'h33, 1'b1);
    join
    wait_cyc(2 * CPB);
    chk("sim_count", evq.size(), 3);
    if (evq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("sim_port", evq[i].port, i);
        chk("sim_data", int'(evq[i].data), 17 * (i + 1));
      end
      chk("sim_consec1", evq[1].cy - evq[0].cy, 1);
      chk("sim_consec2", evq[2].cy - evq[1].cy, 1);
    end
    evq.delete();

    // Directed table
    foreach (tabla[i]) begin
      send(tabla[i].port, tabla[i].data, tabla[i].stop);
      wait_cyc(2 * CPB);
      if (tabla[i].stop) expect_one("tbl", tabla[i].port, tabla[i].data);
      else begin
        chk("tbl_noev", evq.size(), 0);
        evq.delete();
      end
      chk("tbl_err", int'(cnt), tabla[i].exp_err);
    end
    model_err = 2;

    // Glitch on C shorter than half a bit, then a real frame
    rx[2] = 1'b0;
    wait_cyc(4);
    rx[2] = 1'b1;
    wait_cyc(3 * CPB);
    chk("glitch_noev", evq.size(), 0);
    chk("glitch_err", int'(cnt), model_err);
    send(2, 8'h5C, 1'b1);
    wait_cyc(2 * CPB);
    expect_one("after_glitch", 2, 8'h5C);

    // Randomized concurrent frames
    for (int r = 0; r < 8; r++) begin
      logic       en [3];
      logic       ok [3];
      logic [7:0] b  [3];
      int         off[3];
      int         nexp, nbad, found;
      nexp = 0; nbad = 0;
      for (int p = 0; p < 3; p++) begin
        en[p]  = ($urandom_range(0, 3) != 0);
        ok[p]  = ($urandom_range(0, 4) != 0);
        b[p]   = 8'($urandom);
        off[p] = $urandom_range(0, 24);
        if (en[p] && ok[p]) nexp++;
        if (en[p] && !ok[p]) nbad++;
      end
      fork
        begin wait_cyc(off[0]); if (en[0]) send(0, b[0], ok[0]); end
        begin wait_cyc(off[1]); if (en[1]) send(1, b[1], ok[1]); end
        begin wait_cyc(off[2]); if (en[2]) send(2, b[2], ok[2]); end
      join
      wait_cyc(2 * CPB);
      chk("rand_count", evq.size(), nexp);
      for (int p = 0; p < 3; p++) begin
        if (en[p] && ok[p]) begin
          found = 0;
          foreach (evq[k]) if (evq[k].port == p && evq[k].data == b[p]) found++;
          chk($sformatf("rand_found_p%0d", p), found, 1);
        end
      end
      model_err = (model_err + nbad > 15) ? 15 : model_err + nbad;
      chk("rand_err", int'(cnt), model_err);
      evq.delete();
    end

    // Reset in the middle of data bit 3 on A
    evq.delete();
    fork
      send(0, 8'h3C, 1'b1);
      begin
        wait_cyc(4 * CPB + 6);
        #3 reinicio = 1'b0;
        #1;
        chk("midrst_strobes", int'({finC, finB, finA}), 0);
        chk("midrst_dato", int'(dato), 0);
        chk("midrst_cnt", int'(cnt), 0);
      end
    join
    wait_cyc(2);
    reinicio = 1'b1;
    model_err = 0;
    wait_cyc(2 * CPB);
    chk("midrst_noev", evq.size(), 0);
    send(0, 8'h81, 1'b1);
    wait_cyc(2 * CPB);
    expect_one("after_rst", 0, 8'h81);

    // Saturation: 17 framing errors on A
    for (int i = 0; i < 17; i++) begin
      send(0, 8'($urandom), 1'b0);
      wait_cyc(CPB);
      model_err = (model_err == 15) ? 15 : model_err + 1;
    end
    chk("sat_noev", evq.size(), 0);
    chk("sat_err", int'(cnt), model_err);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
